// File: rtl/fc_hwpe_stream_ctrl.sv
// Register-programmed strided-read job sequencer for the FC HWPE slot.
// Streams LEN words over N TCDM read ports and accumulates a 32-bit checksum.
module fc_hwpe_stream_ctrl #(
    parameter int N_MASTER_PORT = 4,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          periph_req_i,
    output logic                          periph_gnt_o,
    input  logic [31:0]                   periph_add_i,
    input  logic                          periph_we_i,
    input  logic [31:0]                   periph_wdata_i,
    input  logic [3:0]                    periph_be_i,
    output logic                          periph_r_valid_o,
    output logic [31:0]                   periph_r_rdata_o,
    output logic [N_MASTER_PORT-1:0]      tcdm_req_o,
    input  logic [N_MASTER_PORT-1:0]      tcdm_gnt_i,
    output logic [N_MASTER_PORT*32-1:0]   tcdm_add_o,
    output logic [N_MASTER_PORT-1:0]      tcdm_wen_o,
    output logic [N_MASTER_PORT*4-1:0]    tcdm_be_o,
    output logic [N_MASTER_PORT*32-1:0]   tcdm_wdata_o,
    input  logic [N_MASTER_PORT*32-1:0]   tcdm_r_rdata_i,
    input  logic [N_MASTER_PORT-1:0]      tcdm_r_valid_i,
    output logic [1:0]                    evt_o,
    output logic                          busy_o
);

    // Word indices run past LEN by up to N before a port stops, so give headroom.
    localparam int IW = LEN_WIDTH + 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [31:0]            src_q;
    logic [31:0]            stride_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [31:0]            result_q;
    logic                   done_q;
    logic                   err_q;
    logic [IW-1:0]          rsp_cnt_q;
    logic [IW-1:0]          idx_q  [N_MASTER_PORT];
    logic [31:0]            addr_q [N_MASTER_PORT];

    logic [2:0]             reg_sel;
    logic                   cfg_wr;
    logic                   cfg_rd;
    logic                   busy;
    logic                   trig_idle;
    logic                   trig_busy;
    logic                   clr_wr;
    logic [31:0]            rd_val;
    logic [31:0]            rsp_sum;
    logic [IW-1:0]          rsp_num;
    logic [IW-1:0]          rsp_total;
    logic [31:0]            port_step;
    logic                   unused_ok;

    assign reg_sel      = periph_add_i[4:2];
    assign cfg_wr       = periph_req_i & periph_we_i;
    assign cfg_rd       = periph_req_i & ~periph_we_i;
    assign busy         = (state != IDLE);
    assign busy_o       = busy;
    assign trig_idle    = cfg_wr && (reg_sel == 3'd0) && !busy;
    assign trig_busy    = cfg_wr && (reg_sel == 3'd0) && busy;
    assign clr_wr       = cfg_wr && (reg_sel == 3'd6);
    assign periph_gnt_o = periph_req_i;
    assign port_step    = stride_q * 32'(N_MASTER_PORT);
    assign rsp_total    = rsp_cnt_q + rsp_num;
    assign unused_ok    = ^{periph_be_i, periph_add_i[31:5], periph_add_i[1:0]};

    assign tcdm_wen_o   = '1;
    assign tcdm_be_o    = '1;
    assign tcdm_wdata_o = '0;

    for (genvar p = 0; p < N_MASTER_PORT; p++) begin : g_port
        assign tcdm_req_o[p]          = (state == RUN) && (idx_q[p] < IW'(len_q));
        assign tcdm_add_o[p*32 +: 32] = addr_q[p];
    end

    always_comb begin
        rsp_sum = '0;
        rsp_num = '0;
        for (int p = 0; p < N_MASTER_PORT; p++) begin
            if (tcdm_r_valid_i[p]) begin
                rsp_sum = rsp_sum + tcdm_r_rdata_i[p*32 +: 32];
                rsp_num = rsp_num + IW'(1);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            3'd1:    rd_val = {29'd0, err_q, done_q, busy};
            3'd2:    rd_val = src_q;
            3'd3:    rd_val = 32'(len_q);
            3'd4:    rd_val = stride_q;
            3'd5:    rd_val = result_q;
            default: rd_val = '0;
        endcase
    end

    // Per-port address walkers: each port owns words p, p+N, p+2N, ...
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < N_MASTER_PORT; p++) begin
                idx_q[p]  <= '0;
                addr_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_MASTER_PORT; p++) begin
                if (trig_idle) begin
                    idx_q[p]  <= IW'(p);
                    addr_q[p] <= src_q + 32'(p) * stride_q;
                end else if (tcdm_req_o[p] && tcdm_gnt_i[p]) begin
                    idx_q[p]  <= idx_q[p] + IW'(N_MASTER_PORT);
                    addr_q[p] <= addr_q[p] + port_step;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            src_q            <= '0;
            len_q            <= '0;
            stride_q         <= '0;
            result_q         <= '0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            rsp_cnt_q        <= '0;
            evt_o            <= '0;
            periph_r_valid_o <= 1'b0;
            periph_r_rdata_o <= '0;
        end else begin
            periph_r_valid_o <= periph_req_i;
            periph_r_rdata_o <= cfg_rd ? rd_val : '0;
            evt_o            <= {trig_busy, 1'b0};

            if (cfg_wr && !busy) begin
                case (reg_sel)
                    3'd2:    src_q    <= periph_wdata_i;
                    3'd3:    len_q    <= periph_wdata_i[LEN_WIDTH-1:0];
                    3'd4:    stride_q <= periph_wdata_i;
                    default: ;
                endcase
            end

            if (trig_busy) begin
                err_q <= 1'b1;
            end
            if (clr_wr) begin
                err_q <= 1'b0;
                if (!busy) begin
                    done_q <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (trig_idle) begin
                        result_q  <= '0;
                        rsp_cnt_q <= '0;
                        if (len_q == '0) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            evt_o[0] <= 1'b1;
                        end else begin
                            state  <= RUN;
                            done_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    result_q  <= result_q + rsp_sum;
                    rsp_cnt_q <= rsp_total;
                    if (rsp_total == IW'(len_q)) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        evt_o[0] <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_hwpe_stream_ctrl.sv
// Randomized bench for fc_hwpe_stream_ctrl: a word-level job model predicts
// per-port addresses, checksum, event timing and status.
module tb_fc_hwpe_stream_ctrl;

    localparam int N = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            periph_req_i;
    logic            periph_gnt_o;
    logic [31:0]     periph_add_i;
    logic            periph_we_i;
    logic [31:0]     periph_wdata_i;
    logic [3:0]      periph_be_i;
    logic            periph_r_valid_o;
    logic [31:0]     periph_r_rdata_o;
    logic [N-1:0]    tcdm_req_o;
    logic [N-1:0]    tcdm_gnt_i;
    logic [N*32-1:0] tcdm_add_o;
    logic [N-1:0]    tcdm_wen_o;
    logic [N*4-1:0]  tcdm_be_o;
    logic [N*32-1:0] tcdm_wdata_o;
    logic [N*32-1:0] tcdm_r_rdata_i;
    logic [N-1:0]    tcdm_r_valid_i;
    logic [1:0]      evt_o;
    logic            busy_o;

    fc_hwpe_stream_ctrl #(.N_MASTER_PORT(N), .LEN_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .periph_req_i(periph_req_i), .periph_gnt_o(periph_gnt_o),
        .periph_add_i(periph_add_i), .periph_we_i(periph_we_i),
        .periph_wdata_i(periph_wdata_i), .periph_be_i(periph_be_i),
        .periph_r_valid_o(periph_r_valid_o), .periph_r_rdata_o(periph_r_rdata_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
        .tcdm_r_rdata_i(tcdm_r_rdata_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .evt_o(evt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          smp_cyc;
    logic        smp_busy;
    logic [1:0]  smp_evt;
    logic [N-1:0] smp_req;
    logic [N*32-1:0] smp_add;
    int          evt0_cnt = 0;
    int          evt1_cnt = 0;
    int          last_cyc;
    int          trig_cyc;
    logic [N-1:0] low_mask = '0;
    logic        rand_gnt = 1'b0;
    logic [31:0] key = '0;
    logic [31:0] job_src = '0;
    logic [31:0] job_stride = '0;
    int          job_len = 0;
    int          exp_k [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ key;
    endfunction

    function automatic logic [31:0] ref_sum(input logic [31:0] s, input int len, input logic [31:0] st);
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < len; k++) acc = acc + mem(s + 32'(k) * st);
        return acc;
    endfunction

    // One clock: drive grants, check requests against the job model, answer grants next cycle.
    task automatic tick();
        logic [N-1:0]    nxt_valid;
        logic [N*32-1:0] nxt_data;
        for (int p = 0; p < N; p++)
            tcdm_gnt_i[p] = !low_mask[p] && (rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1);
        #1;
        smp_cyc  = cyc;
        smp_busy = busy_o;
        smp_evt  = evt_o;
        smp_req  = tcdm_req_o;
        smp_add  = tcdm_add_o;
        if (evt_o[0]) evt0_cnt++;
        if (evt_o[1]) evt1_cnt++;
        nxt_valid = '0;
        nxt_data  = '0;
        for (int p = 0; p < N; p++) begin
            if (tcdm_req_o[p]) begin
                if (exp_k[p] >= job_len) begin
                    check("req_spurious", {31'd0, tcdm_req_o[p]}, 32'd0);
                end else begin
                    check("req_addr", tcdm_add_o[p*32 +: 32], job_src + 32'(exp_k[p]) * job_stride);
                    if (tcdm_gnt_i[p]) begin
                        nxt_valid[p] = 1'b1;
                        nxt_data[p*32 +: 32] = mem(tcdm_add_o[p*32 +: 32]);
                        exp_k[p] += N;
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
        tcdm_r_valid_i = nxt_valid;
        tcdm_r_rdata_i = nxt_data;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic cfg(input logic we, input logic [2:0] idx, input logic [31:0] wd, output logic [31:0] rd);
        periph_req_i   = 1'b1;
        periph_we_i    = we;
        periph_add_i   = {27'd0, idx, 2'b00};
        periph_wdata_i = wd;
        #1;
        check("cfg_gnt", {31'd0, periph_gnt_o}, 32'd1);
        tick();
        last_cyc     = smp_cyc;
        periph_req_i = 1'b0;
        periph_we_i  = 1'b0;
        #1;
        check("cfg_rvalid", {31'd0, periph_r_valid_o}, 32'd1);
        rd = periph_r_rdata_o;
        if (we) check("cfg_wr_rdata", rd, 32'd0);
    endtask

    task automatic start_job(input logic [31:0] s, input int len, input logic [31:0] st);
        logic [31:0] d;
        cfg(1'b1, 3'd2, s, d);
        cfg(1'b1, 3'd3, 32'(len), d);
        cfg(1'b1, 3'd4, st, d);
        job_src = s;
        job_len = len;
        job_stride = st;
        for (int p = 0; p < N; p++) exp_k[p] = p;
        cfg(1'b1, 3'd0, 32'd0, d);
        trig_cyc = last_cyc;
    endtask

    task automatic wait_done(output int ecyc);
        ecyc = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (smp_evt[0]) begin
                ecyc = smp_cyc;
                break;
            end
        end
        if (ecyc < 0) check("done_timeout", {31'd0, smp_evt[0]}, 32'd1);
    endtask

    task automatic finish_job(input string tag);
        logic [31:0] d;
        for (int p = 0; p < N; p++) check({tag, "_all_issued"}, {31'd0, exp_k[p] >= job_len}, 32'd1);
        cfg(1'b0, 3'd5, 32'd0, d);
        check({tag, "_result"}, d, ref_sum(job_src, job_len, job_stride));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        int ecyc;
        int e0;
        int e1;
        rst_i = 1'b1;
        periph_req_i = 0; periph_add_i = 0; periph_we_i = 0; periph_wdata_i = 0;
        periph_be_i = 4'hF; tcdm_gnt_i = 0; tcdm_r_rdata_i = 0; tcdm_r_valid_i = 0;
        for (int p = 0; p < N; p++) exp_k[p] = 0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req", 32'(tcdm_req_o), 32'd0);
        check("rst_add_lo", tcdm_add_o[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        check("rst_add_hi", tcdm_add_o[127:64] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        check("rst_evt", 32'(evt_o), 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_rvalid", {31'd0, periph_r_valid_o}, 32'd0);
        check("rst_rdata", periph_r_rdata_o, 32'd0);
        check("tcdm_wen", 32'(tcdm_wen_o), 32'hF);
        check("tcdm_be", 32'(tcdm_be_o), 32'hFFFF);
        rst_i = 1'b0;
        @(negedge clk_i);
        for (int r = 1; r < 8; r++) begin
            cfg(1'b0, 3'(r), 32'd0, d);
            check("rst_reg", d, 32'd0);
        end

        // Directed job, all grants high, memory word = address.
        key = 0;
        start_job(32'h1C01_0000, 8, 32'd4);
        tick();
        check("p0_first_req", {31'd0, smp_req[0]}, 32'd1);
        check("p0_first_addr", smp_add[31:0], 32'h1C01_0000);
        tick();
        check("p0_second_addr", smp_add[31:0], 32'h1C01_0010);
        wait_done(ecyc);
        check("evt0_latency", 32'(ecyc - trig_cyc), 32'd4);
        check("busy_in_done", {31'd0, smp_busy}, 32'd1);
        tick();
        check("busy_fall", {31'd0, smp_busy}, 32'd0);
        finish_job("job1");
        cfg(1'b0, 3'd5, 32'd0, d);
        check("job1_const", d, 32'hE008_0070);
        cfg(1'b0, 3'd1, 32'd0, d);
        check("job1_status", d, 32'h2);

        // Same job, port2 grant held low for 5 cycles.
        start_job(32'h1C01_0000, 8, 32'd4);
        low_mask = 4'b0100;
        tick();
        held = smp_add[95:64];
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p2_hold", smp_add[95:64], held);
        end
        low_mask = '0;
        wait_done(ecyc);
        check("evt0_stall_latency", 32'(ecyc - trig_cyc), 32'd9);
        tick();
        finish_job("job2");

        // LEN==0.
        start_job(32'h1C01_0000, 0, 32'd4);
        e0 = evt0_cnt;
        tick();
        check("len0_busy", {31'd0, smp_busy}, 32'd1);
        check("len0_evt", {31'd0, smp_evt[0]}, 32'd1);
        tick();
        check("len0_idle", {31'd0, smp_busy}, 32'd0);
        cfg(1'b0, 3'd5, 32'd0, d);
        check("len0_result", d, 32'd0);
        cfg(1'b0, 3'd1, 32'd0, d);
        check("len0_status", d, 32'h2);
        check("len0_evt_cnt", 32'(evt0_cnt - e0), 32'd1);

        // TRIGGER and LEN write during RUN.
        rand_gnt = 1'b1;
        key = $urandom;
        start_job({$urandom_range(0, 32'hFFFF), 16'h0}, 40, 32'd4);
        e1 = evt1_cnt;
        cfg(1'b1, 3'd0, 32'd0, d);
        cfg(1'b1, 3'd3, 32'd5, d);
        cfg(1'b0, 3'd1, 32'd0, d);
        check("run_status", d, 32'h5);
        wait_done(ecyc);
        tick();
        check("evt1_pulses", 32'(evt1_cnt - e1), 32'd1);
        finish_job("job_err");
        cfg(1'b0, 3'd3, 32'd0, d);
        check("len_kept", d, 32'd40);
        cfg(1'b0, 3'd1, 32'd0, d);
        check("err_status", d, 32'h6);
        cfg(1'b1, 3'd6, 32'd0, d);
        cfg(1'b0, 3'd1, 32'd0, d);
        check("clear_status", d, 32'h0);

        // Negative stride wraps downward through address 0.
        key = $urandom;
        start_job(32'h0000_0008, 10, 32'hFFFF_FFFC);
        wait_done(ecyc);
        tick();
        finish_job("wrap");

        // Random jobs.
        for (int j = 0; j < 8; j++) begin
            key = $urandom;
            e0 = evt0_cnt;
            start_job($urandom, $urandom_range(1, 50), $urandom);
            wait_done(ecyc);
            tick();
            check("rnd_idle", {31'd0, smp_busy}, 32'd0);
            check("rnd_evt_cnt", 32'(evt0_cnt - e0), 32'd1);
            finish_job("rnd");
            cfg(1'b0, 3'd1, 32'd0, d);
            check("rnd_status", d, 32'h2);
        end

        // Reset mid-RUN with ports 1..3 stalled.
        rand_gnt = 1'b0;
        low_mask = 4'b1110;
        start_job(32'h1C01_0100, 20, 32'd4);
        tick();
        tick();
        check("pending_req", 32'(smp_req[3:1]), 32'h7);
        e0 = evt0_cnt;
        e1 = evt1_cnt;
        #1;
        rst_i = 1'b1;
        #1;
        check("mid_rst_req", 32'(tcdm_req_o), 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        tcdm_r_valid_i = '0;
        tcdm_r_rdata_i = '0;
        job_len = 0;
        low_mask = '0;
        @(negedge clk_i);
        tick();
        rst_i = 1'b0;
        tick();
        cfg(1'b0, 3'd1, 32'd0, d);
        check("mid_rst_status", d, 32'h0);
        cfg(1'b0, 3'd5, 32'd0, d);
        check("mid_rst_result", d, 32'h0);
        tick();
        check("mid_rst_no_evt", 32'((evt0_cnt - e0) + (evt1_cnt - e1)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
